detector_seq_ctrl: RTL and testbench
====================================

// Module: detector_seq_ctrl
// PURPOSE
//   Sequencer for the serial sequence-detector FSM (x in, y[1:0] out).
//   Accepts parallel words via valid/ready and shifts them MSB-first into
//   the detector, one bit per clock. Optionally resets the detector at
//   frame start. Returns a per-word summary:
//   - the number of bit-cycles with a nonzero y;
//   - the y value seen after the word's last bit.
//   Sits between the stimulus/host side and one detector instance.
// PARAMETERS
//   WORD_W  8  bits per input word, shifted MSB first (>=2)
//   CNT_W   8  width of hit counter (saturating)
// PORTS
//   clk          in   1        system clock, all logic on rising edge
//   rst          in   1        synchronous, active-high reset
//   in_valid     in   1        input word available
//   in_ready     out  1        controller can accept a word
//   in_data      in   WORD_W   word to shift into detector
//   in_frame     in   1        with word: reset detector before shifting
//   det_x        out  1        serial bit to detector x
//   det_rst      out  1        detector synchronous reset
//   det_y        in   2        detector output y
//   out_valid    out  1        summary available
//   out_ready    in   1        consumer accepts summary
//   out_hits     out  CNT_W    count of sampled det_y != 2'b00 for word
//   out_last_y   out  2        det_y sampled for the word's last bit
// BEHAVIOUR
//   - All outputs registered. Reset values:
//     - in_ready=0, det_x=0, det_rst=1;
//     - out_valid=0, out_hits=0, out_last_y=0;
//     - state=IDLE.
//     det_rst=1 holds the detector in reset while rst is high.
//   - FSM states: IDLE, CLEAR, SHIFT, DRAIN, DONE.
//   - IDLE
//     - in_ready=1, det_x=0, det_rst=0.
//     - Accept when in_valid&&in_ready: latch in_data and clear
//       hits/bit index.
//     - Next state: CLEAR if in_frame=1, else SHIFT.
//   - CLEAR (exactly 1 cycle)
//     - det_rst=1, det_x=0. Next: SHIFT. Detector is out of reset when
//       the first bit is presented.
//   - SHIFT (exactly WORD_W cycles)
//     - det_x = latched word bit WORD_W-1-idx. idx runs 0..WORD_W-1.
//     - After idx=WORD_W-1, go to DRAIN.
//   - y alignment: y for a bit is sampled 2 edges after det_x takes that
//     bit.
//     - Edge 1: detector registers x.
//     - Edge 2: controller samples det_y.
//     - Implement as a 2-stage valid shift register fed by "in SHIFT".
//       Sample only when stage 2 is set.
//   - DRAIN (exactly 2 cycles)
//     - det_x=0. Completes sampling of the last two bits.
//     - Then DONE with out_valid=1.
//   - DONE
//     - out_valid=1; out_hits/out_last_y stable.
//     - in_ready=0 until out_valid&&out_ready, then back to IDLE.
//   - Word-to-word throughput: 1 (IDLE) + [1 CLEAR] + WORD_W + 2 + >=1
//     (DONE) cycles. No overlap between words.
//   - Hit counter: on each sample with det_y != 0, add 1; saturate at
//     2^CNT_W-1, never wrap.
//   - out_last_y: det_y from the sample of bit WORD_W-1.
//   - Detector state persists across words when in_frame=0; only
//     CLEAR/rst reset it.
//   - in_data/in_frame ignored when in_ready=0. in_valid may drop
//     without penalty.
//   - rst mid-operation: abandon the word immediately, return to reset
//     values next edge. No partial summary is emitted.
//   - in_valid and out_ready both high in DONE: only the summary handshake
//     completes. The word is accepted next cycle in IDLE.
// TESTING (WORD_W=8, CNT_W=8)
//   Bench stub detector: y <= {1'b0, x} on clk, cleared by det_rst.
//   1. rst high 3 cycles -> det_rst=1, in_ready=0, out_valid=0;
//      release -> in_ready=1 next cycle.
//   2. word 8'b1011_0011, in_frame=1 -> det_rst pulse 1 cycle, then
//      det_x=1,0,1,1,0,0,1,1 on consecutive cycles -> out_hits=5,
//      out_last_y=2'b01.
//   3. word 8'h00 then 8'hFF, in_frame=0, out_ready=1 ->
//      hits 0/last_y 00, then hits 8/last_y 01.
//   4. out_ready low 5 cycles in DONE -> out_valid and data held,
//      in_ready=0; new word accepted only after handshake.
//   5. rst asserted at SHIFT idx=3 -> next edge all outputs at reset
//      values; no out_valid for that word.
//   6. Force CNT_W=2, word 8'hFF -> out_hits saturates at 3.

Source files
------------

// File: rtl/detector_seq_ctrl.sv
// Word-to-serial sequencer for a bit-serial detector FSM.
// Shifts each word MSB first and returns the hit count and last y.
module detector_seq_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_frame,
  output logic              det_x,
  output logic              det_rst,
  input  logic [1:0]        det_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_hits,
  output logic [1:0]        out_last_y
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              drain_q, drain_d;
  logic [1:0]        vld_q, vld_d;
  logic [CNT_W-1:0]  hits_q, hits_d;
  logic [1:0]        last_y_q, last_y_d;
  logic              in_ready_q, in_ready_d;
  logic              det_x_q, det_x_d;
  logic              det_rst_q, det_rst_d;
  logic              out_valid_q, out_valid_d;

  logic accept;
  logic done_hs;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    drain_d     = drain_q;
    hits_d      = hits_q;
    last_y_d    = last_y_q;
    accept      = in_valid && in_ready_q;
    done_hs     = out_valid_q && out_ready;

    // vld_q[1] marks det_y as the response to a shifted bit
    if (vld_q[1]) begin
      if (det_y != 2'b00 && hits_q != {CNT_W{1'b1}}) begin
        hits_d = hits_q + 1'b1;
      end
      if (state_q == DRAIN) begin
        last_y_d = det_y;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          word_d  = in_data;
          idx_d   = '0;
          hits_d  = '0;
          state_d = in_frame ? CLEAR : SHIFT;
        end
      end
      CLEAR: state_d = SHIFT;
      SHIFT: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE: begin
        if (done_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    vld_d       = {vld_q[0], state_d == SHIFT};
    in_ready_d  = (state_d == IDLE);
    det_rst_d   = (state_d == CLEAR);
    out_valid_d = (state_d == DONE);
    det_x_d     = 1'b0;
    if (state_d == SHIFT) begin
      det_x_d = word_d[LAST_IDX - idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      idx_q       <= '0;
      drain_q     <= 1'b0;
      vld_q       <= 2'b00;
      hits_q      <= '0;
      last_y_q    <= 2'b00;
      in_ready_q  <= 1'b0;
      det_x_q     <= 1'b0;
      det_rst_q   <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      drain_q     <= drain_d;
      vld_q       <= vld_d;
      hits_q      <= hits_d;
      last_y_q    <= last_y_d;
      in_ready_q  <= in_ready_d;
      det_x_q     <= det_x_d;
      det_rst_q   <= det_rst_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign det_x      = det_x_q;
  assign det_rst    = det_rst_q;
  assign out_valid  = out_valid_q;
  assign out_hits   = hits_q;
  assign out_last_y = last_y_q;

endmodule

// File: tb/tb_detector_seq_ctrl.sv
// Bench for detector_seq_ctrl: vector table, scoreboard, corner sequences.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_detector_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_frame = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready, det_x, det_rst, out_valid;
  logic [1:0] det_y, out_last_y;
  logic [7:0] out_hits;

  logic       in_ready2, det_x2, det_rst2, out_valid2;
  logic [1:0] det_y2, out_last_y2;
  logic [1:0] out_hits2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  detector_seq_ctrl #(.WORD_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_frame(in_frame),
    .det_x(det_x), .det_rst(det_rst), .det_y(det_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hits(out_hits), .out_last_y(out_last_y)
  );

  detector_seq_ctrl #(.WORD_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_frame(in_frame),
    .det_x(det_x2), .det_rst(det_rst2), .det_y(det_y2),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_hits(out_hits2), .out_last_y(out_last_y2)
  );

  // stub detectors: y follows x by one clock
  always @(posedge clk) begin
    if (det_rst) det_y <= 2'b00;
    else det_y <= {1'b0, det_x};
    if (det_rst2) det_y2 <= 2'b00;
    else det_y2 <= {1'b0, det_x2};
  end

  typedef struct {
    logic [7:0] data;
    logic       frame;
    logic [7:0] hits;
    logic [1:0] last_y;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];
  vec_t got;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_summary: got hits %0d expected none", out_hits);
      end else begin
        got = sb.pop_front();
        check("hits", 32'(out_hits), 32'(got.hits));
        check("last_y", 32'(out_last_y), 32'(got.last_y));
        check("sat_hits", 32'(out_hits2),
              (got.hits > 8'd3) ? 32'd3 : 32'(got.hits));
        check("sat_valid", 32'(out_valid2), 32'd1);
      end
    end
  end

  task automatic send_word(input vec_t v, input bit push);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = v.data;
    in_frame = v.frame;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 32'd1, 32'd0);
    else if (push) sb.push_back(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [7:0] pat;
    int n;
    vecs[0] = '{8'h00, 1'b0, 8'd0, 2'b00};
    vecs[1] = '{8'hFF, 1'b0, 8'd8, 2'b01};
    vecs[2] = '{8'h80, 1'b0, 8'd1, 2'b00};
    vecs[3] = '{8'h01, 1'b1, 8'd1, 2'b01};
    vecs[4] = '{8'h5A, 1'b0, 8'd4, 2'b00};
    vecs[5] = '{8'hB3, 1'b0, 8'd5, 2'b01};

    // reset values
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_det_rst", 32'(det_rst), 32'd1);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
    end
    check("rst_det_x", 32'(det_x), 32'd0);
    check("rst_hits", 32'(out_hits), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready_lat", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_det_rst", 32'(det_rst), 32'd0);

    // framed word: one clear cycle then MSB-first bits
    pat = 8'b1011_0011;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = pat;
    in_frame = 1'b1;
    sb.push_back('{pat, 1'b1, 8'd5, 2'b01});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("clear_det_rst", 32'(det_rst), 32'd1);
    check("clear_det_x", 32'(det_x), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("shift_det_x", 32'(det_x), 32'(pat[7-i]));
      check("shift_det_rst", 32'(det_rst), 32'd0);
    end
    wait_empty();

    // vector table
    for (int i = 0; i < 6; i++) begin
      send_word(vecs[i], 1'b1);
    end
    wait_empty();

    // back-pressure in DONE
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_word(vecs[4], 1'b1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'h0F;
    in_frame = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_hits", 32'(out_hits), 32'd4);
      check("bp_last_y", 32'(out_last_y), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    sb.push_back('{8'h0F, 1'b0, 8'd4, 2'b01});
    @(negedge clk);
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_accepted", 32'(in_ready), 32'd0);
    wait_empty();

    // reset in the middle of SHIFT
    v = '{8'hFF, 1'b0, 8'd8, 2'b01};
    send_word(v, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_det_x_idx3", 32'(det_x), 32'd1);
    @(negedge clk);
    check("mid_det_rst", 32'(det_rst), 32'd1);
    check("mid_in_ready", 32'(in_ready), 32'd0);
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_det_x", 32'(det_x), 32'd0);
    check("mid_hits", 32'(out_hits), 32'd0);
    check("mid_last_y", 32'(out_last_y), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("mid_no_summary", 32'(n), 32'd0);
    check("mid_in_ready_back", 32'(in_ready), 32'd1);

    // saturation on the narrow counter after recovery
    send_word(vecs[1], 1'b1);
    wait_empty();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
